// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation encodings, status register flag positions
// and 6502 opcode {aaa,cc} group constants.
package cpu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_EOR  = 5'd4,
        ALU_ASL  = 5'd5,
        ALU_LSR  = 5'd6,
        ALU_ROL  = 5'd7,
        ALU_ROR  = 5'd8,
        ALU_INC  = 5'd9,
        ALU_DEC  = 5'd10,
        ALU_PASS = 5'd11,
        ALU_BIT  = 5'd12
    } alu_mode_t;

    // Bit positions inside the processor status register (bit 5 is unused).
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [4:0] OP_ORA = 5'b000_01;
    localparam logic [4:0] OP_AND = 5'b001_01;
    localparam logic [4:0] OP_EOR = 5'b010_01;
    localparam logic [4:0] OP_ADC = 5'b011_01;
    localparam logic [4:0] OP_STA = 5'b100_01;
    localparam logic [4:0] OP_LDA = 5'b101_01;
    localparam logic [4:0] OP_CMP = 5'b110_01;
    localparam logic [4:0] OP_SBC = 5'b111_01;
    localparam logic [4:0] OP_ASL = 5'b000_10;
    localparam logic [4:0] OP_ROL = 5'b001_10;
    localparam logic [4:0] OP_LSR = 5'b010_10;
    localparam logic [4:0] OP_ROR = 5'b011_10;
    localparam logic [4:0] OP_STX = 5'b100_10;
    localparam logic [4:0] OP_LDX = 5'b101_10;
    localparam logic [4:0] OP_DEC = 5'b110_10;
    localparam logic [4:0] OP_INC = 5'b111_10;
    localparam logic [4:0] OP_BIT = 5'b001_00;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-bit 6502-style ALU (binary mode only) producing result and N/V/Z/C.
module alu_core
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [4:0] mode,
    input  logic       cin,
    output logic [7:0] r,
    output logic       c,
    output logic       v,
    output logic       z,
    output logic       n
);

    logic [8:0] sum_s;
    logic [7:0] res_s;
    logic       c_s;
    logic       v_s;
    logic       z_s;
    logic       n_s;

    // Result, carry and overflow per operation; unknown modes yield zero with carry passed through.
    always_comb begin
        sum_s = 9'd0;
        res_s = 8'd0;
        c_s   = cin;
        v_s   = 1'b0;
        case (alu_mode_t'(mode))
            ALU_ADD: begin
                sum_s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                res_s = sum_s[7:0];
                c_s   = sum_s[8];
                v_s   = (a[7] == b[7]) && (res_s[7] != a[7]);
            end
            ALU_SUB: begin
                // Subtract as a + ~b + cin, so carry set means no borrow.
                sum_s = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
                res_s = sum_s[7:0];
                c_s   = sum_s[8];
                v_s   = (a[7] != b[7]) && (res_s[7] != a[7]);
            end
            ALU_AND:  res_s = a & b;
            ALU_OR:   res_s = a | b;
            ALU_EOR:  res_s = a ^ b;
            ALU_ASL: begin
                res_s = {a[6:0], 1'b0};
                c_s   = a[7];
            end
            ALU_LSR: begin
                res_s = {1'b0, a[7:1]};
                c_s   = a[0];
            end
            ALU_ROL: begin
                res_s = {a[6:0], cin};
                c_s   = a[7];
            end
            ALU_ROR: begin
                res_s = {cin, a[7:1]};
                c_s   = a[0];
            end
            ALU_INC:  res_s = a + 8'd1;
            ALU_DEC:  res_s = a - 8'd1;
            ALU_PASS: res_s = b;
            ALU_BIT: begin
                res_s = a & b;
                v_s   = b[6];
            end
            default: begin
                res_s = 8'd0;
                c_s   = cin;
                v_s   = 1'b0;
            end
        endcase
    end

    // Z and N follow the result, except BIT which takes N from the memory operand.
    always_comb begin
        z_s = (res_s == 8'd0);
        if (alu_mode_t'(mode) == ALU_BIT) begin
            n_s = b[7];
        end else begin
            n_s = res_s[7];
        end
    end

    assign r = res_s;
    assign c = c_s;
    assign v = v_s;
    assign z = z_s;
    assign n = n_s;

endmodule

// File: rtl/alu_pc_unit.sv
// CPU datapath slice: combinational ALU plus the 16-bit program counter register.
module alu_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alu_a,
    input  logic [7:0]  alu_b,
    input  logic [4:0]  alu_mode,
    input  logic        carry_in,
    output logic [7:0]  alu_out,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero,
    output logic        sign,
    input  logic [15:0] pc_in,
    input  logic        pc_load,
    input  logic        pc_inc,
    output logic [15:0] pc_out
);

    logic [15:0] pc_r;

    alu_core u_alu_core (
        .a    (alu_a),
        .b    (alu_b),
        .mode (alu_mode),
        .cin  (carry_in),
        .r    (alu_out),
        .c    (carry_out),
        .v    (overflow),
        .z    (zero),
        .n    (sign)
    );

    // Program counter: load wins over increment; increment wraps at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= PC_RESET;
        end else if (pc_load) begin
            pc_r <= pc_in;
        end else if (pc_inc) begin
            pc_r <= pc_r + 16'd1;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc_out = pc_r;

endmodule

// File: tb/tb_alu_pc_unit.sv
// Scoreboard bench for alu_pc_unit: directed and random stimulus checked against an arithmetic model.
module tb_alu_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_mode;
    logic        carry_in;
    logic [7:0]  alu_out;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic        sign;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc_out;

    typedef struct {
        int          mode;
        int          a;
        int          b;
        int          cin;
        logic [7:0]  r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] pc_model;

    alu_pc_unit #(.PC_RESET(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .pc_in     (pc_in),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    // Reference ALU from signed/unsigned integer arithmetic.
    function automatic exp_t model(input int mode, input int a, input int b, input int cin,
                                   input logic [15:0] pc);
        exp_t e;
        int r, c, v, sa, sb, s;
        r = 0; c = cin; v = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (mode)
            0: begin
                s = a + b + cin; r = s % 256; c = (s > 255) ? 1 : 0;
                s = sa + sb + cin; v = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                s = a - b - (1 - cin); c = (s >= 0) ? 1 : 0; r = (s + 256) % 256;
                s = sa - sb - (1 - cin); v = (s > 127 || s < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 256; c = a / 128; end
            6: begin r = a / 2; c = a % 2; end
            7: begin r = (a * 2 + cin) % 256; c = a / 128; end
            8: begin r = a / 2 + cin * 128; c = a % 2; end
            9: r = (a + 1) % 256;
            10: r = (a + 255) % 256;
            11: r = b;
            12: begin r = a & b; v = (b / 64) % 2; end
            default: r = 0;
        endcase
        e.mode = mode; e.a = a; e.b = b; e.cin = cin;
        e.r  = 8'(r);
        e.c  = (c != 0);
        e.v  = (v != 0);
        e.z  = (r == 0);
        e.n  = (mode == 12) ? (b >= 128) : (r >= 128);
        e.pc = pc;
        return e;
    endfunction

    task automatic chk_bit(input string name, input exp_t e, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s mode=%0d a=%02h b=%02h cin=%0d: got %b expected %b",
                     name, e.mode, e.a, e.b, e.cin, got, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; pop one expectation per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (alu_out !== e.r) begin
                n_fail++;
                $display("FAIL alu_out mode=%0d a=%02h b=%02h cin=%0d: got %02h expected %02h",
                         e.mode, e.a, e.b, e.cin, alu_out, e.r);
            end
            chk_bit("carry", e, carry_out, e.c);
            chk_bit("overflow", e, overflow, e.v);
            chk_bit("zero", e, zero, e.z);
            chk_bit("sign", e, sign, e.n);
            n_checks++;
            if (pc_out !== e.pc) begin
                n_fail++;
                $display("FAIL pc_out: got %04h expected %04h", pc_out, e.pc);
            end
        end
    end

    // One clock of stimulus: drive after the edge, queue the expectation, advance the PC model.
    task automatic cyc(input int mode, input int a, input int b, input int cin,
                       input logic [15:0] pin, input logic ld, input logic inc);
        @(posedge clk);
        #1;
        alu_mode = 5'(mode); alu_a = 8'(a); alu_b = 8'(b); carry_in = (cin != 0);
        pc_in = pin; pc_load = ld; pc_inc = inc;
        sb_q.push_back(model(mode, a, b, cin, pc_model));
        if (ld) pc_model = pin;
        else if (inc) pc_model = pc_model + 16'd1;
        else pc_model = pc_model;
    endtask

    // Assert reset mid-run with a load and increment pending; they must be discarded.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; pc_in = 16'h1234; pc_load = 1'b1; pc_inc = 1'b1;
        pc_model = 16'h0000;
        #1;
        n_checks++;
        if (pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_midrun: got %04h expected 0000", pc_out);
        end
        sb_q.push_back(model(int'(alu_mode), int'(alu_a), int'(alu_b), int'(carry_in), pc_model));
        @(posedge clk);
        #1;
        sb_q.push_back(model(int'(alu_mode), int'(alu_a), int'(alu_b), int'(carry_in), pc_model));
        rst = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
    endtask

    int dir_tab[17][4] = '{
        '{0, 8'h50, 8'h50, 0}, '{0, 8'hFF, 8'h01, 0}, '{1, 8'h00, 8'h01, 1},
        '{1, 8'h80, 8'h01, 1}, '{2, 8'hF0, 8'h0F, 1}, '{8, 8'h01, 8'h00, 1},
        '{5, 8'h80, 8'h00, 0}, '{12, 8'h01, 8'hC0, 0}, '{9, 8'hFF, 8'h00, 0},
        '{10, 8'h00, 8'h00, 1}, '{3, 8'h12, 8'h81, 0}, '{4, 8'hFF, 8'h0F, 1},
        '{6, 8'h01, 8'h00, 0}, '{7, 8'h80, 8'h00, 1}, '{11, 8'h3C, 8'h80, 0},
        '{13, 8'hAA, 8'h55, 1}, '{31, 8'hFF, 8'hFF, 0}
    };

    initial begin
        rst = 1'b1; alu_a = 8'h00; alu_b = 8'h00; alu_mode = 5'd0; carry_in = 1'b0;
        pc_in = 16'h5555; pc_load = 1'b0; pc_inc = 1'b0;
        pc_model = 16'h0000;
        #2;
        n_checks++;
        if (pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pc: got %04h expected 0000", pc_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors; PC: three increments, load FFFF, wrap increment, load+inc C000.
        for (int i = 0; i < 17; i++) begin
            logic [15:0] pin;
            logic        ld, inc;
            pin = 16'h0000; ld = 1'b0; inc = 1'b0;
            if (i < 3) inc = 1'b1;
            else if (i == 3) begin pin = 16'hFFFF; ld = 1'b1; end
            else if (i == 4) inc = 1'b1;
            else if (i == 5) begin pin = 16'hC000; ld = 1'b1; inc = 1'b1; end
            else if (i == 8) inc = 1'b1;
            cyc(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3], pin, ld, inc);
        end

        do_reset();
        cyc(0, 8'h01, 8'h01, 0, 16'h0000, 1'b0, 1'b1);
        cyc(0, 8'h7F, 8'h01, 0, 16'h0000, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            int mode;
            if ($urandom_range(0, 3) == 0) mode = int'($urandom_range(13, 31));
            else mode = int'($urandom_range(0, 12));
            cyc(mode, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            if (i == 200) do_reset();
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
